// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register numbers, SR/Cause field positions and the
// coprocessor-0 instruction encodings the controller decodes.
package cp0_pkg;

  localparam logic [4:0] CP0_COUNT   = 5'd9;
  localparam logic [4:0] CP0_COMPARE = 5'd11;
  localparam logic [4:0] CP0_SR      = 5'd12;
  localparam logic [4:0] CP0_CAUSE   = 5'd13;
  localparam logic [4:0] CP0_EPC     = 5'd14;
  localparam logic [4:0] CP0_PRID    = 5'd15;

  localparam int SR_IE_BIT    = 0;
  localparam int SR_EXL_BIT   = 1;
  localparam int SR_IM_LSB    = 10;
  localparam int SR_IM_MSB    = 15;
  localparam int CAUSE_IP_LSB = 10;
  localparam int CAUSE_IP_MSB = 15;

  localparam logic [5:0] OP_COP0    = 6'b010000;
  localparam logic [4:0] COP0_MF    = 5'b00000;
  localparam logic [4:0] COP0_MT    = 5'b00100;
  localparam logic [5:0] FUNC_ERET  = 6'b011000;

  localparam logic [31:0] COMPARE_RST = 32'hFFFF_FFFF;

  // Assemble the architecturally visible SR word; unimplemented bits read 0.
  function automatic logic [31:0] sr_pack(input logic [5:0] im,
                                          input logic exl,
                                          input logic ie);
    logic [31:0] w;
    w = 32'h0;
    w[SR_IM_MSB:SR_IM_LSB] = im;
    w[SR_EXL_BIT] = exl;
    w[SR_IE_BIT]  = ie;
    return w;
  endfunction

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer: free-running Count, Compare, and sticky match flag TI.
module cp0_timer
  import cp0_pkg::*;
(
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        wr_count_i,
  input  logic        wr_compare_i,
  input  logic [31:0] din_i,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic        ti_o
);

  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic        ti_q, ti_d;

  // Next-state: a Count write replaces the increment; a Compare write
  // clears TI even if the match lands in the same cycle.
  always_comb begin
    count_d   = count_q + 32'd1;
    compare_d = compare_q;
    ti_d      = ti_q | (count_q == compare_q);
    if (wr_count_i) begin
      count_d = din_i;
    end
    if (wr_compare_i) begin
      compare_d = din_i;
      ti_d      = 1'b0;
    end
  end

  // Timer state registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_q   <= 32'h0;
      compare_q <= COMPARE_RST;
      ti_q      <= 1'b0;
    end else begin
      count_q   <= count_d;
      compare_q <= compare_d;
      ti_q      <= ti_d;
    end
  end

  assign count_o   = count_q;
  assign compare_o = compare_q;
  assign ti_o      = ti_q;

endmodule

// File: rtl/cp0.sv
// System coprocessor 0: SR/Cause/EPC/PrID plus Count/Compare, interrupt
// request generation and exception entry/return bookkeeping.
module cp0
  import cp0_pkg::*;
#(
  parameter logic [31:0] PRID     = 32'h0000_2018,
  parameter bit          TIMER_EN = 1'b1
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [31:2] pc_i,
  input  logic [4:0]  sel_i,
  input  logic [31:0] din_i,
  input  logic        wen_i,
  input  logic        exl_set_i,
  input  logic        exl_clr_i,
  input  logic [7:2]  hwint_i,
  output logic [31:0] dout_o,
  output logic [31:2] epc_o,
  output logic        irq_o
);

  logic [5:0]  im_q, im_d;
  logic        exl_q, exl_d;
  logic        ie_q, ie_d;
  logic [5:0]  ip_q, ip_d;
  logic [31:2] epc_q, epc_d;

  logic        wr_sr, wr_epc, wr_count, wr_compare;
  logic [31:0] count, compare;
  logic        ti;

  assign wr_sr      = wen_i && (sel_i == CP0_SR);
  assign wr_epc     = wen_i && (sel_i == CP0_EPC);
  assign wr_count   = wen_i && (sel_i == CP0_COUNT);
  assign wr_compare = wen_i && (sel_i == CP0_COMPARE);

  cp0_timer u_timer (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .wr_count_i   (wr_count),
    .wr_compare_i (wr_compare),
    .din_i        (din_i),
    .count_o      (count),
    .compare_o    (compare),
    .ti_o         (ti)
  );

  // Next-state: later assignments override earlier ones, giving
  // exl_set over exl_clr over MTC0 for the fields they share.
  always_comb begin
    im_d  = im_q;
    exl_d = exl_q;
    ie_d  = ie_q;
    epc_d = epc_q;
    ip_d  = {hwint_i[7] | (TIMER_EN & ti), hwint_i[6:2]};
    if (wr_sr) begin
      im_d  = din_i[SR_IM_MSB:SR_IM_LSB];
      exl_d = din_i[SR_EXL_BIT];
      ie_d  = din_i[SR_IE_BIT];
    end
    if (wr_epc) begin
      epc_d = din_i[31:2];
    end
    if (exl_clr_i) begin
      exl_d = 1'b0;
    end
    if (exl_set_i) begin
      exl_d = 1'b1;
      epc_d = pc_i;
    end
  end

  // Architectural register state with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      im_q  <= 6'h0;
      exl_q <= 1'b0;
      ie_q  <= 1'b0;
      ip_q  <= 6'h0;
      epc_q <= 30'h0;
    end else begin
      im_q  <= im_d;
      exl_q <= exl_d;
      ie_q  <= ie_d;
      ip_q  <= ip_d;
      epc_q <= epc_d;
    end
  end

  // MFC0 read mux; shows pre-edge state, no bypass of same-cycle writes.
  always_comb begin
    dout_o = 32'h0;
    case (sel_i)
      CP0_SR:      dout_o = sr_pack(im_q, exl_q, ie_q);
      CP0_CAUSE:   dout_o[CAUSE_IP_MSB:CAUSE_IP_LSB] = ip_q;
      CP0_EPC:     dout_o = {epc_q, 2'b00};
      CP0_PRID:    dout_o = PRID;
      CP0_COUNT:   dout_o = TIMER_EN ? count : 32'h0;
      CP0_COMPARE: dout_o = TIMER_EN ? compare : 32'h0;
      default:     dout_o = 32'h0;
    endcase
  end

  assign irq_o = (|(ip_q & im_q)) & ie_q & ~exl_q;
  assign epc_o = epc_q;

endmodule
